// File: rtl/ramen_order_scheduler.sv
// ramen_order_scheduler
//   Front-end controller for the ramen shop datapath. Round-robin arbitrates
//   N_REQ order counters and serializes each granted order onto the shop's
//   two-beat in_valid protocol (type beat, then portion beat). It owns
//   shop_selling for the sales-day session, returns a per-order response to
//   the winning requester, and reports day totals when the shop closes.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/type/portion  per-requester order request (level, held until req_ready)
//   req_ready             one-hot grant, combinational in READY
//   close_req             pulse: next issued order is the last of the day
//   rsp_valid/rsp_success one-hot 1-cycle response to the granted requester
//   shop_*                registered drive to / inputs from the shop datapath
//   day_done/day_gain     session-finished pulse and registered total gain
//   day_orders/day_fails  issued / unsuccessful orders this session (saturating)
//   err_timeout           sticky shop-timeout flag, cleared only by reset
module ramen_order_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [2*N_REQ-1:0]   req_type,
    input  logic [N_REQ-1:0]     req_portion,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 close_req,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic                 rsp_success,
    output logic                 shop_selling,
    output logic                 shop_in_valid,
    output logic [1:0]           shop_ramen_type,
    output logic                 shop_portion,
    input  logic                 shop_out_valid_order,
    input  logic                 shop_success,
    input  logic                 shop_out_valid_tot,
    input  logic [14:0]          shop_total_gain,
    output logic                 day_done,
    output logic [14:0]          day_gain,
    output logic [7:0]           day_orders,
    output logic [7:0]           day_fails,
    output logic                 err_timeout
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_READY, S_ISSUE_T, S_ISSUE_P, S_WAIT, S_CLOSE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
    logic              portion_q, portion_d;
    logic              final_q, final_d;
    logic              close_pending_q, close_pending_d;
    logic              session_open_q, session_open_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic              rsp_success_q, rsp_success_d;
    logic              shop_selling_q, shop_selling_d;
    logic              shop_in_valid_q, shop_in_valid_d;
    logic [1:0]        shop_ramen_type_q, shop_ramen_type_d;
    logic              shop_portion_q, shop_portion_d;
    logic              day_done_q, day_done_d;
    logic [14:0]       day_gain_q, day_gain_d;
    logic [7:0]        day_orders_q, day_orders_d;
    logic [7:0]        day_fails_q, day_fails_d;
    logic              err_timeout_q, err_timeout_d;

    // Round-robin candidates: position k is the requester k steps after ptr.
    logic [IDX_W-1:0]  cand_idx [N_REQ];
    logic [N_REQ-1:0]  cand_hit;
    logic [1:0]        type_arr [N_REQ];
    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rr
        assign cand_idx[gi] = IDX_W'((int'(ptr_q) + gi) % N_REQ);
        assign cand_hit[gi] = req_valid[cand_idx[gi]];
        assign type_arr[gi] = req_type[2*gi +: 2];
    end

    // Scan from the far end so the candidate closest to ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d           = state_q;
        ptr_d             = ptr_q;
        grant_idx_d       = grant_idx_q;
        portion_d         = portion_q;
        final_d           = final_q;
        close_pending_d   = close_pending_q;
        session_open_d    = session_open_q;
        wait_cnt_d        = wait_cnt_q;
        day_gain_d        = day_gain_q;
        day_orders_d      = day_orders_q;
        day_fails_d       = day_fails_q;
        err_timeout_d     = err_timeout_q;
        rsp_valid_d       = '0;
        rsp_success_d     = 1'b0;
        day_done_d        = 1'b0;
        shop_selling_d    = 1'b0;
        shop_in_valid_d   = 1'b0;
        shop_ramen_type_d = 2'd0;
        shop_portion_d    = 1'b0;
        req_ready         = '0;

        // Totals stay visible for the day_done cycle, then restart.
        if (day_done_q) begin
            day_orders_d = '0;
            day_fails_d  = '0;
        end

        // A session is open from the first ISSUE_T, so an order in flight
        // implies an open session; a close with nothing open is dropped.
        if (close_req && session_open_q && state_q != S_CLOSE && state_q != S_ERR)
            close_pending_d = 1'b1;

        // Registered outputs are computed for the state being entered.
        case (state_q)
            S_READY: begin
                shop_selling_d = session_open_q;
                if (grant_found && rst_n) begin
                    req_ready[grant_idx] = 1'b1;
                    grant_idx_d       = grant_idx;
                    portion_d         = req_portion[grant_idx];
                    ptr_d             = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    session_open_d    = 1'b1;
                    shop_selling_d    = 1'b1;
                    shop_in_valid_d   = 1'b1;
                    shop_ramen_type_d = type_arr[grant_idx];
                    state_d           = S_ISSUE_T;
                end
            end
            S_ISSUE_T: begin
                shop_selling_d  = 1'b1;
                shop_in_valid_d = 1'b1;
                shop_portion_d  = portion_q;
                state_d         = S_ISSUE_P;
            end
            S_ISSUE_P: begin
                day_orders_d   = sat_inc(day_orders_q);
                final_d        = close_pending_q || close_req;
                shop_selling_d = !(close_pending_q || close_req);
                wait_cnt_d     = '0;
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                shop_selling_d = !final_q;
                if (shop_out_valid_order) begin
                    rsp_valid_d[grant_idx_q] = 1'b1;
                    rsp_success_d = shop_success;
                    if (!shop_success)
                        day_fails_d = sat_inc(day_fails_q);
                    state_d = final_q ? S_CLOSE : S_READY;
                end else if (wait_cnt_q >= CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle without an answer.
                    rsp_valid_d[grant_idx_q] = 1'b1;
                    err_timeout_d  = 1'b1;
                    shop_selling_d = 1'b0;
                    state_d        = S_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_CLOSE: begin
                if (shop_out_valid_tot) begin
                    day_done_d      = 1'b1;
                    day_gain_d      = shop_total_gain;
                    session_open_d  = 1'b0;
                    close_pending_d = 1'b0;
                    final_d         = 1'b0;
                    state_d         = S_READY;
                end
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_READY;
            ptr_q             <= '0;
            grant_idx_q       <= '0;
            portion_q         <= 1'b0;
            final_q           <= 1'b0;
            close_pending_q   <= 1'b0;
            session_open_q    <= 1'b0;
            wait_cnt_q        <= '0;
            rsp_valid_q       <= '0;
            rsp_success_q     <= 1'b0;
            shop_selling_q    <= 1'b0;
            shop_in_valid_q   <= 1'b0;
            shop_ramen_type_q <= 2'd0;
            shop_portion_q    <= 1'b0;
            day_done_q        <= 1'b0;
            day_gain_q        <= '0;
            day_orders_q      <= '0;
            day_fails_q       <= '0;
            err_timeout_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            ptr_q             <= ptr_d;
            grant_idx_q       <= grant_idx_d;
            portion_q         <= portion_d;
            final_q           <= final_d;
            close_pending_q   <= close_pending_d;
            session_open_q    <= session_open_d;
            wait_cnt_q        <= wait_cnt_d;
            rsp_valid_q       <= rsp_valid_d;
            rsp_success_q     <= rsp_success_d;
            shop_selling_q    <= shop_selling_d;
            shop_in_valid_q   <= shop_in_valid_d;
            shop_ramen_type_q <= shop_ramen_type_d;
            shop_portion_q    <= shop_portion_d;
            day_done_q        <= day_done_d;
            day_gain_q        <= day_gain_d;
            day_orders_q      <= day_orders_d;
            day_fails_q       <= day_fails_d;
            err_timeout_q     <= err_timeout_d;
        end
    end

    assign rsp_valid       = rsp_valid_q;
    assign rsp_success     = rsp_success_q;
    assign shop_selling    = shop_selling_q;
    assign shop_in_valid   = shop_in_valid_q;
    assign shop_ramen_type = shop_ramen_type_q;
    assign shop_portion    = shop_portion_q;
    assign day_done        = day_done_q;
    assign day_gain        = day_gain_q;
    assign day_orders      = day_orders_q;
    assign day_fails       = day_fails_q;
    assign err_timeout     = err_timeout_q;

endmodule

// File: tb/tb_ramen_order_scheduler.sv
// tb_ramen_order_scheduler
//   Directed stimulus for ramen_order_scheduler with a scoreboard: expected
//   grants, responses and day reports are queued when stimulus is issued and
//   a negedge monitor pops and compares whenever the DUT presents them.
//   A small shop model answers each order two cycles after WAIT entry.
module tb_ramen_order_scheduler;
    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_portion, req_ready, rsp_valid;
    logic [2*N-1:0] req_type;
    logic           close_req, rsp_success, shop_selling, shop_in_valid, shop_portion;
    logic [1:0]     shop_ramen_type;
    logic           shop_out_valid_order, shop_success, shop_out_valid_tot;
    logic [14:0]    shop_total_gain, day_gain;
    logic           day_done, err_timeout;
    logic [7:0]     day_orders, day_fails;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { int gain; int orders; int fails; } day_t;
    int   exp_grant_q[$];
    int   exp_rsp_q[$];      // idx*2 + success
    day_t exp_day_q[$];
    int   shop_plan_q[$];
    bit   shop_answer_en = 1'b1;
    bit   auto_drop = 1'b1;
    logic outstanding = 1'b0;
    logic [N-1:0] granted = '0;

    always #5 clk = ~clk;

    ramen_order_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_type(req_type), .req_portion(req_portion),
        .req_ready(req_ready), .close_req(close_req),
        .rsp_valid(rsp_valid), .rsp_success(rsp_success),
        .shop_selling(shop_selling), .shop_in_valid(shop_in_valid),
        .shop_ramen_type(shop_ramen_type), .shop_portion(shop_portion),
        .shop_out_valid_order(shop_out_valid_order), .shop_success(shop_success),
        .shop_out_valid_tot(shop_out_valid_tot), .shop_total_gain(shop_total_gain),
        .day_done(day_done), .day_gain(day_gain),
        .day_orders(day_orders), .day_fails(day_fails),
        .err_timeout(err_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    int   mon_e;
    day_t mon_d;
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 1'b0;
        end else begin
            if (rsp_valid != '0) begin
                $display("tb: rsp valid=%b success=%0d", rsp_valid, rsp_success);
                if (exp_rsp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rsp_unexpected: got rsp_valid=%b, expected none", rsp_valid);
                end else begin
                    mon_e = exp_rsp_q.pop_front();
                    check("rsp_valid", rsp_valid, 1 << (mon_e / 2));
                    check("rsp_success", rsp_success, mon_e % 2);
                end
                outstanding = 1'b0;
            end
            if (req_ready != '0) begin
                $display("tb: grant ready=%b", req_ready);
                check("grant_after_rsp", outstanding, 0);
                if (exp_grant_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL grant_unexpected: got req_ready=%b, expected none", req_ready);
                end else begin
                    check("grant", req_ready, 1 << exp_grant_q.pop_front());
                end
                outstanding = 1'b1;
            end
            if (day_done) begin
                $display("tb: day_done gain=%0d orders=%0d fails=%0d", day_gain, day_orders, day_fails);
                if (exp_day_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL day_unexpected: got day_done=1, expected none");
                end else begin
                    mon_d = exp_day_q.pop_front();
                    check("day_gain", day_gain, mon_d.gain);
                    check("day_orders", day_orders, mon_d.orders);
                    check("day_fails", day_fails, mon_d.fails);
                end
            end
        end
    end

    // Shop model: answers on the second cycle of WAIT.
    initial begin
        shop_out_valid_order = 1'b0;
        shop_success = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (shop_in_valid && rst_n) begin
                repeat (3) begin @(posedge clk); #1; end
                if (shop_answer_en) begin
                    shop_success = (shop_plan_q.size() != 0) ? shop_plan_q.pop_front() : 1'b1;
                    shop_out_valid_order = 1'b1;
                    @(posedge clk); #1;
                    shop_out_valid_order = 1'b0;
                    shop_success = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        granted = req_ready;
        @(posedge clk); #1;
        if (auto_drop) req_valid = req_valid & ~granted;
    endtask

    task automatic do_reset();
        check("queues_drained", exp_grant_q.size() + exp_rsp_q.size() + exp_day_q.size(), 0);
        req_valid = '0; close_req = 1'b0; shop_out_valid_tot = 1'b0; shop_total_gain = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_order(input int idx, input int typ, input int por, input int succ, input bit close_it);
        bit got;
        exp_grant_q.push_back(idx);
        exp_rsp_q.push_back(idx * 2 + succ);
        shop_plan_q.push_back(succ);
        req_type[2*idx +: 2] = typ[1:0];
        req_portion[idx] = por[0];
        req_valid[idx] = 1'b1;
        close_req = close_it;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            step();
            close_req = 1'b0;
            if (granted[idx]) check("issue_type", shop_ramen_type, typ);
            if (rsp_valid != '0) got = 1'b1;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL order_timeout: got no rsp for req %0d, expected rsp within 30 cycles", idx);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_valid = '0; req_type = '0; req_portion = '0; close_req = 1'b0;
        shop_out_valid_tot = 1'b0; shop_total_gain = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {req_ready, rsp_valid, rsp_success, shop_selling, shop_in_valid,
                             shop_ramen_type, shop_portion, day_done, err_timeout}, 0);
        check("reset_gain_orders", {day_gain, day_orders}, 0);
        check("reset_fails", day_fails, 0);
        rst_n = 1'b1;

        // Single req0 TK large.
        exp_grant_q.push_back(0); exp_rsp_q.push_back(1); shop_plan_q.push_back(1);
        req_type = '0; req_portion = 4'b0001; req_valid = 4'b0001;
        #1 check("t1_ready_t0", req_ready, 4'b0001);
        step();
        check("t1_valid_t1", shop_in_valid, 1);
        check("t1_type_t1", shop_ramen_type, 0);
        check("t1_selling_t1", shop_selling, 1);
        check("t1_portion_t1", shop_portion, 0);
        step();
        check("t1_valid_t2", shop_in_valid, 1);
        check("t1_portion_t2", shop_portion, 1);
        step();
        check("t1_valid_t3", shop_in_valid, 0);
        check("t1_orders_t3", day_orders, 1);
        step();
        check("t1_rsp_t4", rsp_valid, 0);
        step();
        check("t1_rsp_t5", rsp_valid, 4'b0001);
        check("t1_success_t5", rsp_success, 1);
        step();

        // All four held: round robin, close during req2's ISSUE_P.
        do_reset();
        auto_drop = 1'b0;
        req_type = {2'd3, 2'd2, 2'd1, 2'd0};
        req_portion = 4'b0100;
        foreach (exp_rsp_q[i]) ; // queues already drained
        exp_grant_q.push_back(0); exp_grant_q.push_back(1); exp_grant_q.push_back(2);
        exp_grant_q.push_back(3); exp_grant_q.push_back(0);
        exp_rsp_q.push_back(1); exp_rsp_q.push_back(3); exp_rsp_q.push_back(5);
        exp_rsp_q.push_back(7); exp_rsp_q.push_back(1);
        req_valid = 4'b1111;
        for (int c = 0; c < 60; c++) begin
            step();
            if (granted == 4'b0100) break;
        end
        check("rr_type_req2", shop_ramen_type, 2);
        step();
        close_req = 1'b1;
        check("rr_issue_p_valid", shop_in_valid, 1);
        check("rr_issue_p_portion", shop_portion, 1);
        step();
        close_req = 1'b0;
        check("close_wait_selling", shop_selling, 0);
        step();
        step();
        check("close_rsp_req2", rsp_valid, 4'b0100);
        for (int c = 0; c < 4; c++) begin
            check("close_no_grant", req_ready, 0);
            check("close_selling", shop_selling, 0);
            step();
        end
        exp_day_q.push_back('{gain: 450, orders: 3, fails: 0});
        shop_out_valid_tot = 1'b1; shop_total_gain = 15'd450;
        step();
        shop_out_valid_tot = 1'b0; shop_total_gain = '0;
        check("day_done_pulse", day_done, 1);
        check("day_done_grant3", req_ready, 4'b1000);
        step();
        check("orders_cleared", day_orders, 0);
        check("day_gain_held", day_gain, 450);
        for (int c = 0; c < 40; c++) begin
            step();
            if (granted == 4'b0001) break;
        end
        req_valid = '0;
        auto_drop = 1'b1;
        repeat (8) step();

        // Shop never answers: timeout into ERR.
        shop_answer_en = 1'b0;
        exp_grant_q.push_back(1); exp_rsp_q.push_back(2);
        req_valid = 4'b0010;
        #1 check("to_ready", req_ready, 4'b0010);
        step(); step(); step();
        repeat (TO - 1) step();
        check("to_rsp_early", rsp_valid, 0);
        step();
        check("to_rsp", rsp_valid, 4'b0010);
        check("to_success", rsp_success, 0);
        check("to_err", err_timeout, 1);
        req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("err_no_grant", req_ready, 0);
            check("err_shop_idle", {shop_in_valid, shop_selling}, 0);
            step();
        end
        check("err_sticky", err_timeout, 1);
        do_reset();
        shop_answer_en = 1'b1;
        check("err_cleared", err_timeout, 0);

        // Five orders, two failures, close on the last.
        close_req = 1'b1;   // no session open: dropped
        step();
        close_req = 1'b0;
        do_order(0, 1, 0, 1, 1'b0);
        check("dropped_close_selling", shop_selling, 1);
        check("e_orders_1", day_orders, 1);
        do_order(1, 2, 1, 0, 1'b0);
        do_order(2, 3, 0, 1, 1'b0);
        do_order(3, 0, 1, 0, 1'b0);
        do_order(0, 2, 1, 1, 1'b1);
        check("e_close_selling", shop_selling, 0);
        check("e_orders_5", day_orders, 5);
        check("e_fails_2", day_fails, 2);
        exp_day_q.push_back('{gain: 1234, orders: 5, fails: 2});
        shop_out_valid_tot = 1'b1; shop_total_gain = 15'd1234;
        step();
        shop_out_valid_tot = 1'b0; shop_total_gain = '0;
        step();
        check("e_gain_held", day_gain, 1234);
        check("e_counts_cleared", {day_orders, day_fails}, 0);
        do_order(1, 3, 1, 1, 1'b0);
        check("e_new_session_orders", day_orders, 1);
        step();

        // Reset during ISSUE_P.
        do_reset();
        shop_answer_en = 1'b0;
        exp_grant_q.push_back(0);
        req_type = 8'h03; req_portion = 4'b0001; req_valid = 4'b0001;
        step();
        step();
        check("rst_issue_p_valid", shop_in_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {req_ready, rsp_valid, rsp_success, shop_selling, shop_in_valid,
                               shop_ramen_type, shop_portion, day_done, err_timeout}, 0);
        check("rst_mid_counts", {day_orders, day_fails}, 0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        shop_answer_en = 1'b1;
        exp_grant_q.push_back(3); exp_rsp_q.push_back(7); shop_plan_q.push_back(1);
        req_valid = 4'b1000;
        #1 check("rst_req3_ready", req_ready, 4'b1000);
        repeat (8) step();

        check("final_queues_drained", exp_grant_q.size() + exp_rsp_q.size() + exp_day_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
